// File: rtl/fifo_unpacker_pkg.sv
// Shared helpers for the FIFO read unpacker: lane-count arithmetic,
// parameter legality, and lane extraction from a wide FIFO word.
package fifo_unpacker_pkg;

    // Widest FIFO word the lane selector can handle.
    localparam int MAX_W = 1024;

    // Number of narrow beats produced from one FIFO word.
    function automatic int calc_num_lanes(input int in_w, input int out_w);
        return (out_w > 0) ? (in_w / out_w) : 0;
    endfunction

    // Width of the lane index counter.
    function automatic int calc_lane_idx_w(input int in_w, input int out_w);
        int n;
        n = calc_num_lanes(in_w, out_w);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Word must split evenly into at least two beats.
    function automatic bit params_legal(input int in_w, input int out_w);
        return (out_w > 0) && (in_w <= MAX_W) && (in_w % out_w == 0) &&
               (in_w / out_w >= 2);
    endfunction

    // Returns the selected lane in the low out_w bits of the result.
    // With msb_first the lane order is reversed, so idx 0 picks the top lane.
    function automatic logic [MAX_W-1:0] lane_select(
        input logic [MAX_W-1:0] word,
        input int unsigned      idx,
        input int unsigned      out_w,
        input int unsigned      num_lanes,
        input bit               msb_first
    );
        int unsigned lane;
        lane = msb_first ? (num_lanes - 1 - idx) : idx;
        return word >> (lane * out_w);
    endfunction

endpackage

// File: rtl/fifo_read_unpacker_if.sv
// Bus bundle between the unpacker, the FIFO read port and the beat consumer.
// Optional member out_last exists only when FIFO_UNPACKER_LAST_EN is defined.
//
// Handshake: a beat moves when out_valid & out_ready are both high at a
// rising clk edge. Once out_valid is high it stays high with out_data held
// until that transfer happens (flush is the only exception). fifo_pop is a
// plain read strobe; fifo_data is valid the cycle after it.
interface fifo_read_unpacker_if #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
);
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [IN_WIDTH-1:0]  fifo_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
`ifdef FIFO_UNPACKER_LAST_EN
    logic                 out_last;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_pop, out_valid, out_data, out_last
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_pop, out_valid, out_data, out_last
    );
`else
    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_pop, out_valid, out_data
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_pop, out_valid, out_data
    );
`endif
endinterface

// File: rtl/fifo_read_unpacker.sv
// Pops wide words from a standard (1-cycle latency) FIFO read port and
// re-emits each as NUM_LANES narrow beats on a valid/ready stream.
// A two-entry buffer (buf + skid) hides the read latency so the stream
// sustains one beat per cycle. Optional macro: FIFO_UNPACKER_LAST_EN adds
// out_last marking the final beat of each word.
module fifo_read_unpacker
    import fifo_unpacker_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    output logic                 busy,
    fifo_read_unpacker_if.master bus
);

    localparam int NUM_LANES  = calc_num_lanes(IN_WIDTH, OUT_WIDTH);
    localparam int LANE_IDX_W = calc_lane_idx_w(IN_WIDTH, OUT_WIDTH);
    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(NUM_LANES - 1);

    generate
        if (!params_legal(IN_WIDTH, OUT_WIDTH)) begin : g_bad_params
            $error("fifo_read_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH giving at least 2 lanes");
        end
    endgenerate

    logic                  pending,    pending_nxt;
    logic                  buf_valid,  buf_valid_nxt;
    logic [IN_WIDTH-1:0]   buf_data,   buf_data_nxt;
    logic                  skid_valid, skid_valid_nxt;
    logic [IN_WIDTH-1:0]   skid_data,  skid_data_nxt;
    logic [LANE_IDX_W-1:0] lane_idx,   lane_idx_nxt;

    logic [1:0] occupancy;
    logic       pop;
    logic       xfer;
    logic       on_last_lane;
    logic       word_done;

    // Words held or in flight; a pop is only allowed while this is below 2.
    always_comb begin
        occupancy = {1'b0, buf_valid} + {1'b0, skid_valid} + {1'b0, pending};
    end

    // No credit is taken for a same-cycle output transfer, which keeps the
    // skid entry from ever being overwritten while it holds a word.
    assign pop          = resetn & ~bus.fifo_empty & ~flush & (occupancy < 2'd2);
    assign bus.fifo_pop = pop;

    assign bus.out_valid = buf_valid & ~flush;
    assign on_last_lane  = (lane_idx == LAST_LANE);
    assign xfer          = bus.out_valid & bus.out_ready;
    assign word_done     = xfer & on_last_lane;
    assign busy          = buf_valid | skid_valid | pending;

    assign bus.out_data = OUT_WIDTH'(lane_select(MAX_W'(buf_data), 32'(lane_idx),
                                                 OUT_WIDTH, NUM_LANES, MSB_FIRST != 0));

`ifdef FIFO_UNPACKER_LAST_EN
    assign bus.out_last = bus.out_valid & on_last_lane;
`endif

    // Buffer / lane counter update: advance lanes on transfers, refill buf
    // from skid or the returning FIFO word when a word completes, and park
    // returning data in buf (if empty) or skid otherwise.
    always_comb begin
        pending_nxt    = pending;
        buf_valid_nxt  = buf_valid;
        buf_data_nxt   = buf_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        lane_idx_nxt   = lane_idx;

        if (flush) begin
            pending_nxt    = 1'b0;
            buf_valid_nxt  = 1'b0;
            skid_valid_nxt = 1'b0;
            lane_idx_nxt   = '0;
        end else begin
            pending_nxt = pop;

            if (xfer) begin
                if (on_last_lane) begin
                    lane_idx_nxt = '0;
                    if (skid_valid) begin
                        buf_data_nxt = skid_data;
                        if (pending) begin
                            skid_data_nxt = bus.fifo_data;
                        end else begin
                            skid_valid_nxt = 1'b0;
                        end
                    end else if (pending) begin
                        buf_data_nxt = bus.fifo_data;
                    end else begin
                        buf_valid_nxt = 1'b0;
                    end
                end else begin
                    lane_idx_nxt = lane_idx + LANE_IDX_W'(1);
                end
            end

            if (pending && !word_done) begin
                if (!buf_valid) begin
                    buf_valid_nxt = 1'b1;
                    buf_data_nxt  = bus.fifo_data;
                end else begin
                    skid_valid_nxt = 1'b1;
                    skid_data_nxt  = bus.fifo_data;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending    <= 1'b0;
            buf_valid  <= 1'b0;
            buf_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            lane_idx   <= '0;
        end else begin
            pending    <= pending_nxt;
            buf_valid  <= buf_valid_nxt;
            buf_data   <= buf_data_nxt;
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
            lane_idx   <= lane_idx_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_read_unpacker.sv
// Bench for fifo_read_unpacker: an LSB-first instance with a FIFO model and
// beat scoreboard, plus an MSB-first instance for lane ordering.
module tb_fifo_read_unpacker;

    localparam int IN_W  = 64;
    localparam int OUT_W = 16;
    localparam int LANES = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic flush;
    logic flush2;
    logic busy;
    logic busy2;

    int total = 0;
    int bad   = 0;

    fifo_read_unpacker_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();
    fifo_read_unpacker_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus2 ();

    fifo_read_unpacker #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .MSB_FIRST(0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .busy   (busy),
        .bus    (bus)
    );

    fifo_read_unpacker #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .MSB_FIRST(1)) dut2 (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush2),
        .busy   (busy2),
        .bus    (bus2)
    );

    // ---------------- FIFO models (standard read, 1-cycle latency) ----------------
    logic [IN_W-1:0] mem  [0:511];
    logic [IN_W-1:0] mem2 [0:15];
    int wr_ptr = 0, rd_ptr = 0, pop_cnt = 0;
    int wr2 = 0, rd2 = 0;

    assign bus.fifo_empty  = (rd_ptr == wr_ptr);
    assign bus2.fifo_empty = (rd2 == wr2);

    always @(posedge clk) begin
        if (bus.fifo_pop) begin
            bus.fifo_data <= mem[rd_ptr[8:0]];
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
        if (bus2.fifo_pop) begin
            bus2.fifo_data <= mem2[rd2[3:0]];
            rd2 <= rd2 + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] sb_exp;

    always @(negedge clk) begin
        if (resetn && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_beat: got %h, required no beat", bus.out_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (bus.out_data !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_beat: got %h, required %h", bus.out_data, sb_exp);
                end
            end
        end
    end

    // ---------------- continuous protocol checks ----------------
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.fifo_empty) begin
                total++;
                if (bus.fifo_pop !== 1'b0) begin
                    bad++;
                    $display("FAIL pop_while_empty: fifo_pop=%b, required 0", bus.fifo_pop);
                end
            end
            if (dut.pending && dut.skid_valid) begin
                total++;
                if (!(bus.out_valid && bus.out_ready && dut.lane_idx == 2'(LANES - 1))) begin
                    bad++;
                    $display("FAIL skid_overwrite: pending with skid full and no word completion");
                end
            end
            if (prev_stall && !flush) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
                    bad++;
                    $display("FAIL stall_stable: valid=%b data=%h, required valid=1 data=%h",
                             bus.out_valid, bus.out_data, prev_data);
                end
            end
        end
        prev_stall = resetn && bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [IN_W-1:0] w, input bit expect_all);
        mem[wr_ptr[8:0]] = w;
        wr_ptr = wr_ptr + 1;
        if (expect_all) begin
            for (int l = 0; l < LANES; l++) exp_q.push_back(w[l*OUT_W +: OUT_W]);
        end
    endtask

    task automatic push2(input logic [IN_W-1:0] w);
        mem2[wr2[3:0]] = w;
        wr2 = wr2 + 1;
    endtask

    // Ends at a negedge where out_valid is high, or ok=0 after the budget.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            if (bus.out_valid) ok = 1'b1;
        end
    endtask

    // Ends at a negedge with the DUT and FIFO idle and all beats seen.
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            tick();
            @(negedge clk);
            if (!busy && bus.fifo_empty && exp_q.size() == 0) ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        flush = 1'b0;
        flush2 = 1'b0;
        bus.out_ready = 1'b1;
        bus2.out_ready = 1'b1;
        bus.fifo_data = '0;
        bus2.fifo_data = '0;
        tick();
        tick();
        push(64'h0004_0003_0002_0001, 1'b1);
        @(negedge clk);
        total++;
        if (bus.fifo_pop !== 1'b0) begin bad++; $display("FAIL reset_pop: got %b, required 0", bus.fifo_pop); end
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", bus.out_valid); end
        total++;
        if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h, required 0000", bus.out_data); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
`ifdef FIFO_UNPACKER_LAST_EN
        total++;
        if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b, required 0", bus.out_last); end
`endif
    endtask

    task automatic test_single();
        logic [OUT_W-1:0] want [4];
        int pops0;
        want = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        pops0 = pop_cnt;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if (bus.fifo_pop !== 1'b1) begin bad++; $display("FAIL single_pop: got %b, required 1", bus.fifo_pop); end
        tick();
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b1 || bus.fifo_pop !== 1'b0) begin
            bad++;
            $display("FAIL single_latency: valid=%b busy=%b pop=%b, required 0 1 0", bus.out_valid, busy, bus.fifo_pop);
        end
        for (int l = 0; l < LANES; l++) begin
            tick();
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== want[l]) begin
                bad++;
                $display("FAIL single_beat%0d: valid=%b data=%h, required 1 %h", l, bus.out_valid, bus.out_data, want[l]);
            end
`ifdef FIFO_UNPACKER_LAST_EN
            total++;
            if (bus.out_last !== (l == LANES - 1)) begin
                bad++;
                $display("FAIL single_last%0d: got %b, required %b", l, bus.out_last, l == LANES - 1);
            end
`endif
        end
        tick();
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done: valid=%b busy=%b, required 0 0", bus.out_valid, busy);
        end
        total++;
        if (pop_cnt - pops0 !== 1) begin bad++; $display("FAIL single_pop_count: got %0d, required 1", pop_cnt - pops0); end
    endtask

    task automatic test_burst();
        logic [IN_W-1:0] w;
        bit ok;
        tick();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int l = 0; l < LANES; l++) w[l*OUT_W +: OUT_W] = 16'hB000 + 16'(i * LANES + l);
            push(w, 1'b1);
        end
        wait_valid(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL burst_start: got no out_valid, required out_valid within budget"); end
        for (int k = 0; k < 8 * LANES; k++) begin
            if (k > 0) begin
                tick();
                @(negedge clk);
            end
            total++;
            if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL burst_gap: beat %0d valid=%b, required 1", k, bus.out_valid); end
        end
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL burst_drain: %0d beats left, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [IN_W-1:0] w;
        bit started;
        bit ok;
        tick();
        for (int i = 0; i < 100; i++) begin
            w = {$urandom(), $urandom()};
            push(w, 1'b1);
        end
        started = 1'b0;
        for (int c = 0; c < 3000 && exp_q.size() > 0; c++) begin
            tick();
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.out_valid) started = 1'b1;
            if (started && exp_q.size() > 0) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy: got %b, required 1", busy); end
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL bp_lossless: %0d beats left, required 0", exp_q.size()); end
        bus.out_ready = 1'b1;
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_idle: busy=%b, required 0", busy); end
    endtask

    task automatic test_msb_first();
        logic [OUT_W-1:0] want [4];
        bit ok;
        want = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
        tick();
        push2(64'h0004_0003_0002_0001);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            if (bus2.out_valid) ok = 1'b1;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL msb_start: got no out_valid, required out_valid within budget"); end
        for (int l = 0; l < LANES; l++) begin
            if (l > 0) begin
                tick();
                @(negedge clk);
            end
            total++;
            if (bus2.out_valid !== 1'b1 || bus2.out_data !== want[l]) begin
                bad++;
                $display("FAIL msb_beat%0d: valid=%b data=%h, required 1 %h", l, bus2.out_valid, bus2.out_data, want[l]);
            end
`ifdef FIFO_UNPACKER_LAST_EN
            total++;
            if (bus2.out_last !== (l == LANES - 1)) begin
                bad++;
                $display("FAIL msb_last%0d: got %b, required %b", l, bus2.out_last, l == LANES - 1);
            end
`endif
        end
        tick();
        @(negedge clk);
        total++;
        if (bus2.out_valid !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL msb_done: valid=%b busy=%b, required 0 0", bus2.out_valid, busy2);
        end
    endtask

    task automatic test_flush();
        logic [IN_W-1:0] a;
        bit ok;
        // Stalled with buf and skid full, two lanes of A already sent.
        tick();
        bus.out_ready = 1'b0;
        a = 64'h00A4_00A3_00A2_00A1;
        push(a, 1'b0);
        exp_q.push_back(a[15:0]);
        exp_q.push_back(a[31:16]);
        push(64'h00B4_00B3_00B2_00B1, 1'b0);
        for (int c = 0; c < 5; c++) tick();
        @(negedge clk);
        total++;
        if (dut.buf_valid !== 1'b1 || dut.skid_valid !== 1'b1) begin
            bad++;
            $display("FAIL flush_setup: buf=%b skid=%b, required 1 1", dut.buf_valid, dut.skid_valid);
        end
        tick();
        bus.out_ready = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        total++;
        if (bus.fifo_pop !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_cycle: pop=%b valid=%b, required 0 0", bus.fifo_pop, bus.out_valid);
        end
`ifdef FIFO_UNPACKER_LAST_EN
        total++;
        if (bus.out_last !== 1'b0) begin bad++; $display("FAIL flush_last: got %b, required 0", bus.out_last); end
`endif
        tick();
        flush = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_after: busy=%b valid=%b, required 0 0", busy, bus.out_valid);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL flush_pre_beats: %0d left, required 0", exp_q.size()); end
        tick();
        bus.out_ready = 1'b1;
        push(64'h0008_0007_0006_0005, 1'b1);
        wait_valid(ok);
        total++;
        if (!ok || bus.out_data !== 16'h0005) begin
            bad++;
            $display("FAIL flush_next_word: valid=%b data=%h, required 1 0005", bus.out_valid, bus.out_data);
        end
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL flush_drain: %0d beats left, required 0", exp_q.size()); end

        // Flush the cycle after a pop: the returning word is discarded.
        tick();
        push(64'h00E4_00E3_00E2_00E1, 1'b0);
        @(negedge clk);
        total++;
        if (bus.fifo_pop !== 1'b1) begin bad++; $display("FAIL flushp_pop: got %b, required 1", bus.fifo_pop); end
        tick();
        flush = 1'b1;
        @(negedge clk);
        total++;
        if (bus.fifo_pop !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flushp_cycle: pop=%b valid=%b, required 0 0", bus.fifo_pop, bus.out_valid);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL flushp_busy: got %b, required 0", busy); end
        tick();
        tick();
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flushp_stale: valid=%b, required 0", bus.out_valid); end
        push(64'h00F4_00F3_00F2_00F1, 1'b1);
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL flushp_drain: %0d beats left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_word();
        logic [IN_W-1:0] g;
        bit ok;
        tick();
        bus.out_ready = 1'b0;
        g = 64'h00C4_00C3_00C2_00C1;
        push(g, 1'b0);
        exp_q.push_back(g[15:0]);
        exp_q.push_back(g[31:16]);
        wait_valid(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_mid_start: got no out_valid, required out_valid within budget"); end
        tick();
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (dut.lane_idx !== 2'd2) begin bad++; $display("FAIL rst_mid_lane: got %0d, required 2", dut.lane_idx); end
        tick();
        resetn = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_immediate: valid=%b busy=%b, required 0 0", bus.out_valid, busy);
        end
        tick();
        tick();
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        push(64'h00D4_00D3_00D2_00D1, 1'b1);
        wait_valid(ok);
        total++;
        if (!ok || bus.out_data !== 16'h00D1) begin
            bad++;
            $display("FAIL rst_mid_next: valid=%b data=%h, required 1 00d1", bus.out_valid, bus.out_data);
        end
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_mid_drain: %0d beats left, required 0", exp_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_msb_first();
        test_flush();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
